// File: rtl/ahb_pkg.sv
// Shared AHB encodings for the 1-master / 2-slave demux: transfer types,
// data-phase select codes and the address decode helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] DSEL_NONE = 2'd0;
    localparam logic [1:0] DSEL_S0   = 2'd1;
    localparam logic [1:0] DSEL_S1   = 2'd2;
    localparam logic [1:0] DSEL_DEF  = 2'd3;

    localparam logic [7:0] UNMAPPED_CNT_MAX = 8'hFF;

    function automatic logic addr_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: one wait state per transfer,
// then OKAY with all-zero read data.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int SZ = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enter,
    input  logic          active,
    output logic          ready,
    output logic [SZ-1:0] rdata
);

    logic wait_q;
    logic wait_d;

    // Wait flag lives exactly one cycle after each entry into the default slave.
    always_comb begin
        wait_d = 1'b0;
        if (enter) begin
            wait_d = 1'b1;
        end else begin
            wait_d = 1'b0;
        end
    end

    // Wait flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Ready and data returned while the default slave owns the data phase.
    always_comb begin
        ready = 1'b1;
        rdata = {SZ{1'b0}};
        if (active) begin
            ready = ~wait_q;
        end else begin
            ready = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_demux_1m2s.sv
// AHB-Lite decoder and response mux: one master, two address-mapped slaves
// plus an internal default slave that counts accesses to unmapped space.
module ahb_demux_1m2s
    import ahb_pkg::*;
#(
    parameter int          SZ      = 64,
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h4000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [SZ-1:0] HWDATA,
    output logic          HREADY,
    output logic [SZ-1:0] HRDATA,
    output logic [31:0]   HADDR_S,
    output logic [1:0]    HTRANS_S,
    output logic          HWRITE_S,
    output logic [2:0]    HSIZE_S,
    output logic [SZ-1:0] HWDATA_S,
    output logic          HSEL_S0,
    output logic          HSEL_S1,
    output logic          HREADY_S,
    input  logic          HREADYOUT_S0,
    input  logic          HREADYOUT_S1,
    input  logic [SZ-1:0] HRDATA_S0,
    input  logic [SZ-1:0] HRDATA_S1,
    output logic [7:0]    UNMAPPED_CNT
);

    logic [1:0]    dsel_q;
    logic [1:0]    dsel_d;
    logic [7:0]    cnt_q;
    logic [7:0]    cnt_d;
    logic          match_s0_s;
    logic          match_s1_s;
    logic          unmapped_s;
    logic          hready_s;
    logic          def_ready_s;
    logic [SZ-1:0] def_rdata_s;
    logic          def_enter_s;
    logic          def_active_s;

    // Address decode and request broadcast; slave 0 wins on overlap.
    always_comb begin
        match_s0_s = addr_match(HADDR, S0_BASE, S0_MASK);
        match_s1_s = addr_match(HADDR, S1_BASE, S1_MASK);
        HSEL_S0    = HTRANS[1] & match_s0_s;
        HSEL_S1    = HTRANS[1] & ~match_s0_s & match_s1_s;
        unmapped_s = HTRANS[1] & ~match_s0_s & ~match_s1_s;
        HADDR_S    = HADDR;
        HTRANS_S   = HTRANS;
        HWRITE_S   = HWRITE;
        HSIZE_S    = HSIZE;
        HWDATA_S   = HWDATA;
    end

    // Response mux driven by the current data-phase owner.
    always_comb begin
        hready_s = 1'b1;
        HRDATA   = {SZ{1'b0}};
        case (dsel_q)
            DSEL_NONE: begin
                hready_s = 1'b1;
            end
            DSEL_S0: begin
                hready_s = HREADYOUT_S0;
                HRDATA   = HRDATA_S0;
            end
            DSEL_S1: begin
                hready_s = HREADYOUT_S1;
                HRDATA   = HRDATA_S1;
            end
            DSEL_DEF: begin
                hready_s = def_ready_s;
                HRDATA   = def_rdata_s;
            end
            default: begin
                hready_s = 1'b1;
            end
        endcase
        HREADY   = hready_s;
        HREADY_S = hready_s;
    end

    // Next data-phase owner and unmapped counter; both frozen during stalls.
    always_comb begin
        dsel_d = dsel_q;
        cnt_d  = cnt_q;
        if (hready_s) begin
            if (!HTRANS[1]) begin
                dsel_d = DSEL_NONE;
            end else if (HSEL_S0) begin
                dsel_d = DSEL_S0;
            end else if (HSEL_S1) begin
                dsel_d = DSEL_S1;
            end else begin
                dsel_d = DSEL_DEF;
            end
            if (unmapped_s && (cnt_q != UNMAPPED_CNT_MAX)) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            dsel_d = dsel_q;
            cnt_d  = cnt_q;
        end
        def_enter_s  = hready_s & unmapped_s;
        def_active_s = (dsel_q == DSEL_DEF);
    end

    // Data-phase select and counter registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q <= DSEL_NONE;
            cnt_q  <= 8'd0;
        end else begin
            dsel_q <= dsel_d;
            cnt_q  <= cnt_d;
        end
    end

    assign UNMAPPED_CNT = cnt_q;

    ahb_default_slave #(
        .SZ(SZ)
    ) u_default_slave (
        .clk   (HCLK),
        .rst   (HRESET),
        .enter (def_enter_s),
        .active(def_active_s),
        .ready (def_ready_s),
        .rdata (def_rdata_s)
    );

endmodule
